// File: rtl/stream_pattern_gen_pkg.sv
// stream_patgen_pkg: shared types and helpers for stream_pattern_gen.
//   - FSM state and pattern mode encodings
//   - PRBS-31 (x^31 + x^28 + 1) tap positions and 32-bit parallel step
//   - LANE_W: width of one pattern lane
package stream_patgen_pkg;

  localparam int LANE_W      = 32;
  localparam int PRBS_W      = 31;
  localparam int PRBS_TAP_HI = 30;  // x^31 term: oldest bit in the register
  localparam int PRBS_TAP_LO = 27;  // x^28 term

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_FIXED = 2'd2,
    MODE_RSVD  = 2'd3   // behaves as fixed
  } mode_t;

  typedef struct packed {
    logic [LANE_W-1:0] word;
    logic [PRBS_W-1:0] state;
  } prbs_step_t;

  // An all-zero register would lock the LFSR, so it is replaced by 1.
  function automatic logic [PRBS_W-1:0] prbs31_seed(input logic [LANE_W-1:0] s);
    return (s[PRBS_W-1:0] == '0) ? PRBS_W'(1) : s[PRBS_W-1:0];
  endfunction

  // Produce the next 32 output bits; the first bit generated lands in the MSB.
  function automatic prbs_step_t prbs31_step32(input logic [PRBS_W-1:0] st);
    prbs_step_t r;
    logic       b;
    r.state = st;
    r.word  = '0;
    for (int i = LANE_W - 1; i >= 0; i--) begin
      b         = r.state[PRBS_TAP_HI] ^ r.state[PRBS_TAP_LO];
      r.word[i] = b;
      r.state   = {r.state[PRBS_W-2:0], b};
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_pattern_gen_lane.sv
// prbs31_lane: one PRBS-31 lane with a 32-bit-per-beat parallel step.
//   clk, areset : clock, synchronous active-high reset
//   i_load      : take the lane seed (i_seed ^ LANE_IDX) and step from it
//   i_adv       : step from the held register
//   i_seed      : common seed word
//   o_word      : word the lane would emit on this cycle's load/advance
module prbs31_lane
  import stream_patgen_pkg::*;
#(
  parameter int LANE_IDX = 0
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [LANE_W-1:0] i_seed,
  output logic [LANE_W-1:0] o_word
);

  logic [PRBS_W-1:0] r_state;
  logic [PRBS_W-1:0] w_src;
  prbs_step_t        w_step;

  // On load the first word is computed straight from the seed so it can be
  // registered on the same edge that starts the burst.
  assign w_src  = i_load ? prbs31_seed(i_seed ^ LANE_W'(LANE_IDX)) : r_state;
  assign w_step = prbs31_step32(w_src);
  assign o_word = w_step.word;

  always_ff @(posedge clk) begin
    if (areset)               r_state <= PRBS_W'(1);
    else if (i_load || i_adv) r_state <= w_step.state;
  end

endmodule

// File: rtl/stream_pattern_gen.sv
// stream_pattern_gen: AXI-Stream test-pattern source, NLINKS = TDATA_WIDTH/32 lanes.
//   clk, areset        : clock, synchronous active-high reset
//   start, stop        : begin burst (IDLE only) / end after current beat
//   mode, seed         : 0 counter, 1 PRBS-31, 2/3 fixed; seed/start value/fixed word
//   burst_len          : beats per burst, 0 = continuous
//   active_links       : lane mask, cleared bit forces lane to zero
//   inject             : corrupt bit 0 of lowest active lane in next loaded beat
//   M_AXIS_TDATA/TVALID/TREADY : stream master
//   busy, done, beat_count     : status
// Build option: define STREAM_PATGEN_INJECT_EN to enable error injection;
// otherwise inject is ignored.
module stream_pattern_gen
  import stream_patgen_pkg::*;
#(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [31:0]            seed,
  input  logic [31:0]            burst_len,
  input  logic [15:0]            active_links,
  input  logic                   inject,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            beat_count
);

  localparam int NLINKS = TDATA_WIDTH / LANE_W;

  state_t                          r_state, w_state_nxt;
  logic [1:0]                      r_mode;
  logic [31:0]                     r_seed, r_burst_len, r_cnt, r_beat_count;
  logic [NLINKS-1:0]               r_links;
  logic [TDATA_WIDTH-1:0]          r_tdata;
  logic                            r_tvalid, r_done;

  logic                            w_hs, w_last;
  logic                            w_load_first, w_load_next, w_load, w_to_idle;
  logic [1:0]                      w_mode;
  logic [31:0]                     w_seed, w_cbase;
  logic [NLINKS-1:0]               w_links, w_flip;
  logic [NLINKS-1:0][LANE_W-1:0]   w_data;
  logic                            w_unused;

  assign w_hs   = r_tvalid && M_AXIS_TREADY;
  assign w_last = w_hs && (r_burst_len != '0) && (r_beat_count + 32'd1 == r_burst_len);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && !stop) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last) w_state_nxt = ST_IDLE;      // last burst beat skips DRAIN
                else if (stop) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_tvalid || w_hs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_load_first = 1'b0;
    w_load_next  = 1'b0;
    case (r_state)
      ST_IDLE: w_load_first = start && !stop;
      ST_RUN:  w_load_next  = w_hs && !w_last && !stop;
      default: ;
    endcase
    w_load    = w_load_first || w_load_next;
    w_to_idle = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
    busy      = (r_state != ST_IDLE);
  end

  // The first beat is built from the live config inputs on the start edge;
  // later beats use the copies latched on that edge.
  assign w_mode  = w_load_first ? mode : r_mode;
  assign w_seed  = w_load_first ? seed : r_seed;
  assign w_links = w_load_first ? active_links[NLINKS-1:0] : r_links;
  assign w_cbase = w_load_first ? seed : r_cnt;

  for (genvar gi = 0; gi < NLINKS; gi++) begin : g_lane
    logic [LANE_W-1:0] w_prbs, w_raw;
    prbs31_lane #(.LANE_IDX(gi)) u_prbs (
      .clk    (clk),
      .areset (areset),
      .i_load (w_load_first),
      .i_adv  (w_load_next),
      .i_seed (seed),
      .o_word (w_prbs)
    );
    assign w_raw = (w_mode == MODE_CNT)  ? w_cbase + LANE_W'(gi) :
                   (w_mode == MODE_PRBS) ? w_prbs : w_seed;
    assign w_data[gi] = (w_links[gi] ? w_raw : '0) ^ {{(LANE_W-1){1'b0}}, w_flip[gi]};
  end

`ifdef STREAM_PATGEN_INJECT_EN
  logic r_inj_pend;
  logic w_found;

  // Flip goes to the lowest active lane only; with no active lane nothing flips
  // but the pending flag still clears on the load.
  always_comb begin
    w_flip  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NLINKS; i++) begin
      if (w_links[i] && !w_found) begin
        w_flip[i] = r_inj_pend;
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (areset) r_inj_pend <= 1'b0;
    else        r_inj_pend <= (r_inj_pend && !w_load) || inject;
  end
`else
  assign w_flip = '0;
`endif

  assign w_unused = ^{active_links, inject};

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (areset) begin
      r_mode       <= '0;
      r_seed       <= '0;
      r_burst_len  <= '0;
      r_links      <= '0;
      r_cnt        <= '0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_done       <= 1'b0;
      r_beat_count <= '0;
    end else begin
      r_done <= w_to_idle;
      if (w_load_first) begin
        r_mode      <= mode;
        r_seed      <= seed;
        r_burst_len <= burst_len;
        r_links     <= active_links[NLINKS-1:0];
      end
      if (w_load) begin
        r_tdata  <= w_data;
        r_tvalid <= 1'b1;
        r_cnt    <= w_cbase + 32'(NLINKS);
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
      end
      if (w_load_first) r_beat_count <= '0;
      else if (w_hs)    r_beat_count <= r_beat_count + 32'd1;
    end
  end

  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TVALID = r_tvalid;
  assign done          = r_done;
  assign beat_count    = r_beat_count;

endmodule

// File: tb/tb_stream_pattern_gen.sv
`timescale 1ns/1ps
module tb_stream_pattern_gen;
  localparam int TW = 64;
  localparam int NL = TW / 32;
`ifdef STREAM_PATGEN_INJECT_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic areset = 1'b1, start = 1'b0, stop = 1'b0, inject = 1'b0, tready = 1'b1;
  logic [1:0]  mode = '0;
  logic [31:0] seed = '0, burst_len = '0;
  logic [15:0] links = '0;
  logic [TW-1:0] tdata;
  logic tvalid, busy, done;
  logic [31:0] beat_count;

  stream_pattern_gen #(.TDATA_WIDTH(TW)) dut (
    .clk(clk), .areset(areset), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .burst_len(burst_len), .active_links(links), .inject(inject),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .busy(busy), .done(done), .beat_count(beat_count));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int popped = 0, done_cnt = 0, cyc = 0, last_hs_cyc = 0, last_done_cyc = 0;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] held;
  bit   held_v = 1'b0;
  bit   rdy_rand = 1'b0;
  logic rdy_val = 1'b1;

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Monitor: protocol checks and scoreboard pops on every handshake.
  always @(negedge clk) begin : mon
    logic [TW-1:0] e;
    if (areset) begin
      held_v = 1'b0;
    end else begin
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (held_v) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, held);
      end
      held_v = tvalid && !tready;
      held   = tdata;
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL beat_extra: got %h, expected no beat", tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat", tdata, e);
        end
        popped++;
        last_hs_cyc = cyc;
      end
    end
  end

  // Reference model: whole burst built from the pattern definitions.
  task automatic push_burst(input logic [1:0] m, input logic [31:0] s, input int n,
                            input logic [15:0] lk, input bit inj);
    logic [TW-1:0] beats [];
    bit            h [];
    logic [31:0]   st, w;
    beats = new[n];
    foreach (beats[k]) beats[k] = '0;
    for (int i = 0; i < NL; i++) begin
      if (m == 2'd1) begin
        // PRBS bit sequence: h[n] = h[n-31] ^ h[n-28], seed bits oldest first.
        h  = new[31 + 32 * n];
        st = s ^ 32'(i);
        if (st[30:0] == 31'd0) st = 32'd1;
        for (int j = 0; j < 31; j++) h[j] = st[30-j];
        for (int j = 31; j < h.size(); j++) h[j] = h[j-31] ^ h[j-28];
      end
      for (int k = 0; k < n; k++) begin
        if (m == 2'd0) w = s + 32'(k * NL + i);
        else if (m == 2'd1) begin
          w = '0;
          for (int b = 0; b < 32; b++) w[31-b] = h[31 + 32*k + b];
        end else w = s;
        if (!lk[i]) w = '0;
        beats[k][i*32 +: 32] = w;
      end
    end
    if (inj && INJ_EN && n > 0) begin
      for (int i = 0; i < NL; i++) begin
        if (lk[i]) begin
          beats[0][i*32] = ~beats[0][i*32];
          break;
        end
      end
    end
    foreach (beats[k]) exp_q.push_back(beats[k]);
  endtask

  task automatic start_burst(input logic [1:0] m, input logic [31:0] s, input logic [31:0] len,
                             input logic [15:0] lk);
    mode = m; seed = s; burst_len = len; links = lk; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble config: the DUT must use its latched copy
    mode = 2'($urandom); seed = $urandom; burst_len = $urandom; links = 16'($urandom);
  endtask

  task automatic wait_done(input int base, input string nm);
    int t = 0;
    while (done_cnt == base && t < 2000) begin @(posedge clk); #1; t++; end
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_done_pulses"}, done_cnt - base, 1);
  endtask

  task automatic wait_beats(input int b0, input int target, input string nm);
    int t = 0;
    while (popped - b0 < target && t < 2000) begin @(posedge clk); #1; t++; end
    chk({nm, "_beats_reached"}, (popped - b0 >= target), 1);
  endtask

  initial begin
    int base, b0;
    logic [31:0] s, len;
    logic [15:0] lk;
    logic [1:0]  m;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_beat_count", beat_count, 0);
    areset = 1'b0;
    @(posedge clk); #1;

    // 1: counter burst, always ready, literal expectations
    rdy_rand = 1'b0; rdy_val = 1'b1;
    exp_q.push_back(64'h00000011_00000010);
    exp_q.push_back(64'h00000013_00000012);
    exp_q.push_back(64'h00000015_00000014);
    base = done_cnt; b0 = popped;
    start_burst(2'd0, 32'h10, 32'd3, 16'hffff);
    chk("t1_tvalid_after_start", tvalid, 1);
    chk("t1_busy", busy, 1);
    wait_done(base, "t1");
    chk("t1_beat_count", beat_count, 3);
    chk("t1_beats", popped - b0, 3);
    chk("t1_done_latency", last_done_cyc - last_hs_cyc, 1);
    chk("t1_busy_idle", busy, 0);
    chk("t1_tvalid_idle", tvalid, 0);

    // 2: same burst under random backpressure, then random bursts
    rdy_rand = 1'b1;
    push_burst(2'd0, 32'h10, 3, 16'hffff, 1'b0);
    base = done_cnt;
    start_burst(2'd0, 32'h10, 32'd3, 16'hffff);
    wait_done(base, "t2");
    chk("t2_beat_count", beat_count, 3);
    chk("t2_queue_empty", exp_q.size(), 0);
    for (int r = 0; r < 8; r++) begin
      m = 2'($urandom_range(0, 3)); s = $urandom; len = $urandom_range(1, 20);
      lk = 16'($urandom);
      push_burst(m, s, int'(len), lk, 1'b0);
      base = done_cnt;
      start_burst(m, s, len, lk);
      wait_done(base, "rnd");
      chk("rnd_beat_count", beat_count, len);
      chk("rnd_queue_empty", exp_q.size(), 0);
    end

    // 3: PRBS continuous, stop after 100 beats
    push_burst(2'd1, 32'd1, 130, 16'hffff, 1'b0);
    base = done_cnt; b0 = popped;
    start_burst(2'd1, 32'd1, 32'd0, 16'hffff);
    chk("t3_prbs_first_lane0", tdata[31:0], 32'h00000012);
    wait_beats(b0, 100, "t3");
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(base, "t3");
    chk("t3_beat_count", beat_count, popped - b0);
    exp_q.delete();

    // 4: repeated inject while idle -> at most one flipped bit (lane 1, beat 0)
    inject = 1'b1; @(posedge clk); #1; inject = 1'b0;
    @(posedge clk); #1;
    inject = 1'b1; @(posedge clk); #1; inject = 1'b0;
    s = $urandom;
    push_burst(2'd0, s, 8, 16'h0002, 1'b1);
    base = done_cnt;
    start_burst(2'd0, s, 32'd8, 16'h0002);
    wait_done(base, "t4");
    chk("t4_beat_count", beat_count, 8);
    chk("t4_queue_empty", exp_q.size(), 0);

    // 5: reset mid-burst
    s = $urandom;
    push_burst(2'd0, s, 60, 16'hffff, 1'b0);
    base = done_cnt; b0 = popped;
    start_burst(2'd0, s, 32'd0, 16'hffff);
    wait_beats(b0, 7, "t5");
    rdy_rand = 1'b0; rdy_val = 1'b0;
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    chk("t5_tvalid", tvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_beat_count", beat_count, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt - base, 0);
    exp_q.delete();
    rdy_val = 1'b1;

    // 6: start and stop together in IDLE
    base = done_cnt;
    mode = 2'd0; seed = $urandom; burst_len = 32'd4; links = 16'hffff;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("t6_tvalid", tvalid, 0);
    chk("t6_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_tvalid_later", tvalid, 0);
    chk("t6_no_done", done_cnt - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1);
  end

endmodule
